adc_multichannel_processor: RTL and testbench

//  Multi-channel ADC post-processor. Sits between the ADC sample interface and the display/consumer logic.
//  Per channel: averages 2**AVG_POW samples (accumulate-and-dump), then scales to display units as (ave*SCALE)>>SHIFT.

---
 rtl/adc_multichannel_processor.sv | 197 +++++++++++++++++++
 tb/tb_adc_multichannel_processor.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_multichannel_processor.sv
// adc_multichannel_processor
//   Multi-channel ADC post-processor. Each channel averages 2**AVG_POW
//   samples (accumulate-and-dump), the average is scaled to display units as
//   (ave*SCALE)>>SHIFT with saturation to OUT_W bits, and the result leaves
//   through a valid/ready output register. A result that finds the output
//   register occupied and not being accepted is dropped and flagged.
//
//   Optional feature macro: ADC_PROC_DROP_CNT_EN
//     defined   -> drop_cnt port and 8-bit saturating dropped-result counter
//     undefined -> no drop_cnt port; overrun flag behaves identically
//
// Ports
//   clk         clock
//   reset       synchronous, active-high reset
//   adc_ready   conversion-done level; each rising edge is one new sample
//   adc_ch      channel tag of adc_data (channels >= NUM_CH are ignored)
//   adc_data    sample value
//   out_valid   output register holds a result
//   out_ready   consumer accepts the result when out_valid & out_ready
//   out_ch      channel of the held result
//   out_ave     averaged sample of the held result
//   out_scaled  scaled, saturated result
//   overrun     sticky flag: a completed result was dropped
//   drop_cnt    saturating count of dropped results (macro-dependent)
//   ovr_clr     clears overrun (and drop_cnt); a same-cycle drop wins
module adc_multichannel_processor #(
  parameter int  DATA_W  = 16,
  parameter int  NUM_CH  = 4,
  parameter int  AVG_POW = 8,
  parameter int  SCALE   = 79993,
  parameter int  SHIFT   = 19,
  parameter int  OUT_W   = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adc_ready,
  input  logic [CH_W-1:0]   adc_ch,
  input  logic [DATA_W-1:0] adc_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [DATA_W-1:0] out_ave,
  output logic [OUT_W-1:0]  out_scaled,
  output logic              overrun,
`ifdef ADC_PROC_DROP_CNT_EN
  output logic [7:0]        drop_cnt,
`endif
  input  logic              ovr_clr
);

  localparam int ACC_W  = DATA_W + AVG_POW;
  localparam int PROD_W = DATA_W + $clog2(SCALE + 1);
  // Wide enough to compare the shifted product against the OUT_W ceiling
  // regardless of which of the two is wider.
  localparam int CMP_W  = ((PROD_W > OUT_W) ? PROD_W : OUT_W) + 1;
  localparam logic [AVG_POW-1:0] CNT_LAST = '1;

  // Edge detect: resets to 1 so a level already high at release is no sample.
  logic ready_r_reg;
  logic stb;
  assign stb = adc_ready & ~ready_r_reg;

  always_ff @(posedge clk) begin
    if (reset) ready_r_reg <= 1'b1;
    else       ready_r_reg <= adc_ready;
  end

  // Per-channel accumulate-and-dump.
  logic [NUM_CH-1:0] done_vec;
  logic [DATA_W-1:0] ave_arr [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [ACC_W-1:0]   acc_reg;
      logic [AVG_POW-1:0] cnt_reg;
      logic               hit;
      logic [ACC_W-1:0]   sum;

      // Out-of-range channel tags match no generate slot and are ignored.
      assign hit          = stb && (adc_ch == CH_W'(gi));
      assign sum          = acc_reg + ACC_W'(adc_data);
      assign done_vec[gi] = hit && (cnt_reg == CNT_LAST);
      // Exact truncating divide by 2**AVG_POW.
      assign ave_arr[gi]  = sum[ACC_W-1:AVG_POW];

      always_ff @(posedge clk) begin
        if (reset) begin
          acc_reg <= '0;
          cnt_reg <= '0;
        end else if (hit) begin
          if (cnt_reg == CNT_LAST) begin
            acc_reg <= '0;
            cnt_reg <= '0;
          end else begin
            acc_reg <= sum;
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end
    end
  endgenerate

  // At most one channel completes per strobe; pick it for S1.
  logic              s1_valid_next;
  logic [CH_W-1:0]   s1_ch_next;
  logic [DATA_W-1:0] s1_ave_next;

  always_comb begin
    s1_valid_next = 1'b0;
    s1_ch_next    = '0;
    s1_ave_next   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (done_vec[i]) begin
        s1_valid_next = 1'b1;
        s1_ch_next    = CH_W'(i);
        s1_ave_next   = ave_arr[i];
      end
    end
  end

  // Free-running pipeline: S1 average -> S2 product -> S3 shift/saturate.
  logic              s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic [CH_W-1:0]   s1_ch_reg, s2_ch_reg, s3_ch_reg;
  logic [DATA_W-1:0] s1_ave_reg, s2_ave_reg, s3_ave_reg;
  logic [PROD_W-1:0] s2_prod_reg;
  logic [OUT_W-1:0]  s3_scaled_reg;

  logic [PROD_W-1:0] shifted;
  logic              sat;
  logic [OUT_W-1:0]  scaled_next;

  assign shifted     = s2_prod_reg >> SHIFT;
  assign sat         = CMP_W'(shifted) > CMP_W'({OUT_W{1'b1}});
  assign scaled_next = sat ? {OUT_W{1'b1}} : OUT_W'(shifted);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= s1_valid_next;
      s2_valid_reg <= s1_valid_reg;
      s3_valid_reg <= s2_valid_reg;
    end
    s1_ch_reg     <= s1_ch_next;
    s1_ave_reg    <= s1_ave_next;
    s2_ch_reg     <= s1_ch_reg;
    s2_ave_reg    <= s1_ave_reg;
    s2_prod_reg   <= PROD_W'(s1_ave_reg) * PROD_W'(SCALE);
    s3_ch_reg     <= s2_ch_reg;
    s3_ave_reg    <= s2_ave_reg;
    s3_scaled_reg <= scaled_next;
  end

  // Output register: accept-and-reload in one cycle keeps out_valid high;
  // a result arriving while the held one is stalled is dropped.
  logic load, drop;
  assign load = s3_valid_reg && (!out_valid || out_ready);
  assign drop = s3_valid_reg && out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_ave    <= '0;
      out_scaled <= '0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        out_valid  <= 1'b1;
        out_ch     <= s3_ch_reg;
        out_ave    <= s3_ave_reg;
        out_scaled <= s3_scaled_reg;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // Set has priority over clear.
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

`ifdef ADC_PROC_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= 8'd0;
    end else if (ovr_clr) begin
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_multichannel_processor.sv
// Testbench for adc_multichannel_processor. Two instances share one stimulus
// stream: dut1 uses the default scaling with NUM_CH=4, dut2 uses SCALE=2,
// SHIFT=0 and NUM_CH=3 (so channel 3 is an out-of-range tag for it).
// A behavioural model (sample queues per channel, a due-time queue of
// results, and the output/overrun rules) is checked on every negedge, and
// directed tests pin specific literal results.
module tb_adc_multichannel_processor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, adc_ready, out_ready, ovr_clr;
  logic [1:0]  adc_ch;
  logic [15:0] adc_data;

  logic        v1, v2, ovr1, ovr2;
  logic [1:0]  ch1o, ch2o;
  logic [15:0] ave1, ave2, sc1, sc2;
`ifdef ADC_PROC_DROP_CNT_EN
  logic [7:0]  dc1, dc2;
`endif

  adc_multichannel_processor #(
    .DATA_W(16), .NUM_CH(4), .AVG_POW(2), .SCALE(79993), .SHIFT(19), .OUT_W(16)
  ) u_dut1 (
    .clk(clk), .reset(reset), .adc_ready(adc_ready), .adc_ch(adc_ch),
    .adc_data(adc_data), .out_valid(v1), .out_ready(out_ready), .out_ch(ch1o),
    .out_ave(ave1), .out_scaled(sc1), .overrun(ovr1),
`ifdef ADC_PROC_DROP_CNT_EN
    .drop_cnt(dc1),
`endif
    .ovr_clr(ovr_clr)
  );

  adc_multichannel_processor #(
    .DATA_W(16), .NUM_CH(3), .AVG_POW(2), .SCALE(2), .SHIFT(0), .OUT_W(16)
  ) u_dut2 (
    .clk(clk), .reset(reset), .adc_ready(adc_ready), .adc_ch(adc_ch),
    .adc_data(adc_data), .out_valid(v2), .out_ready(out_ready), .out_ch(ch2o),
    .out_ave(ave2), .out_scaled(sc2), .overrun(ovr2),
`ifdef ADC_PROC_DROP_CNT_EN
    .drop_cnt(dc2),
`endif
    .ovr_clr(ovr_clr)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nch(input int m);   return (m == 0) ? 4 : 3;     endfunction
  function automatic longint scl(input int m); return (m == 0) ? 79993 : 2; endfunction
  function automatic int shf(input int m);   return (m == 0) ? 19 : 0;    endfunction

  typedef struct {
    longint due;
    int     ch;
    longint ave;
    longint scaled;
  } res_t;

  res_t   pend[2][$];
  longint samp_q[2][4][$];
  logic   m_valid[2];
  int     m_ch[2];
  longint m_ave[2];
  longint m_scaled[2];
  logic   m_ovr[2];
  int     m_drop[2];
  logic   m_prev_ready;
  longint cyc;
  bit     model_live;

  initial begin
    bit     arrive, dropped;
    res_t   r;
    longint s, a, p;
    cyc = 0;
    model_live = 0;
    m_prev_ready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_ch[m] = 0; m_ave[m] = 0; m_scaled[m] = 0;
      m_ovr[m] = 0; m_drop[m] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      model_live = 1;
      if (reset) begin
        for (int m = 0; m < 2; m++) begin
          pend[m].delete();
          for (int c = 0; c < 4; c++) samp_q[m][c].delete();
          m_valid[m] = 0; m_ch[m] = 0; m_ave[m] = 0; m_scaled[m] = 0;
          m_ovr[m] = 0; m_drop[m] = 0;
        end
        m_prev_ready = 1'b1;
      end else begin
        for (int m = 0; m < 2; m++) begin
          arrive = 0;
          dropped = 0;
          if (pend[m].size() > 0 && pend[m][0].due == cyc) begin
            r = pend[m].pop_front();
            arrive = 1;
          end
          if (arrive && m_valid[m] && !out_ready) begin
            dropped = 1;
            m_ovr[m] = 1;
            if (m_drop[m] < 255) m_drop[m]++;
          end else if (arrive) begin
            m_valid[m] = 1; m_ch[m] = r.ch; m_ave[m] = r.ave; m_scaled[m] = r.scaled;
            $display("dut%0d result ch=%0d ave=%0d scaled=%0d", m + 1, r.ch, r.ave, r.scaled);
          end else if (m_valid[m] && out_ready) begin
            m_valid[m] = 0;
          end
          if (ovr_clr) begin
            if (dropped) m_drop[m] = 1;
            else begin m_ovr[m] = 0; m_drop[m] = 0; end
          end
        end
        if (adc_ready && !m_prev_ready) begin
          for (int m = 0; m < 2; m++) begin
            if (int'(adc_ch) < nch(m)) begin
              samp_q[m][adc_ch].push_back(longint'(adc_data));
              if (samp_q[m][adc_ch].size() == 4) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += samp_q[m][adc_ch][k];
                a = s / 4;
                p = (a * scl(m)) >> shf(m);
                if (p > 65535) p = 65535;
                r.due = cyc + 3; r.ch = int'(adc_ch); r.ave = a; r.scaled = p;
                pend[m].push_back(r);
                samp_q[m][adc_ch].delete();
              end
            end
          end
        end
        m_prev_ready = adc_ready;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        check("dut1 out_valid", 64'(v1), 64'(m_valid[0]));
        check("dut1 overrun", 64'(ovr1), 64'(m_ovr[0]));
        if (m_valid[0]) begin
          check("dut1 out_ch", 64'(ch1o), 64'(m_ch[0]));
          check("dut1 out_ave", 64'(ave1), 64'(m_ave[0]));
          check("dut1 out_scaled", 64'(sc1), 64'(m_scaled[0]));
        end
        check("dut2 out_valid", 64'(v2), 64'(m_valid[1]));
        check("dut2 overrun", 64'(ovr2), 64'(m_ovr[1]));
        if (m_valid[1]) begin
          check("dut2 out_ch", 64'(ch2o), 64'(m_ch[1]));
          check("dut2 out_ave", 64'(ave2), 64'(m_ave[1]));
          check("dut2 out_scaled", 64'(sc2), 64'(m_scaled[1]));
        end
`ifdef ADC_PROC_DROP_CNT_EN
        check("dut1 drop_cnt", 64'(dc1), 64'(m_drop[0]));
        check("dut2 drop_cnt", 64'(dc2), 64'(m_drop[1]));
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic sample(input logic [1:0] ch, input logic [15:0] d);
    adc_ch = ch;
    adc_data = d;
    adc_ready = 1'b1;
    @(negedge clk);
    adc_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; adc_ready = 1'b0; adc_ch = '0; adc_data = '0;
    out_ready = 1'b1; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // reset state
    check("reset out_valid", 64'(v1), 64'd0);
    check("reset out_scaled", 64'(sc1), 64'd0);
    check("reset overrun", 64'(ovr1), 64'd0);
    @(negedge clk);

    // 1: full-scale average on ch0, 3-cycle latency
    for (int i = 0; i < 4; i++) sample(2'd0, 16'hFFFF);
    check("t1 latency+1", 64'(v1), 64'd0);
    @(negedge clk);
    check("t1 latency+2", 64'(v1), 64'd0);
    @(negedge clk);
    check("t1 out_valid", 64'(v1), 64'd1);
    check("t1 out_ch", 64'(ch1o), 64'd0);
    check("t1 out_ave", 64'(ave1), 64'hFFFF);
    check("t1 out_scaled", 64'(sc1), 64'd9998);
    check("t1 dut2 sat", 64'(sc2), 64'hFFFF);

    // 2: interleaved ch0/ch1
    for (int i = 0; i < 4; i++) begin
      sample(2'd0, 16'(100 * (i + 1)));
      sample(2'd1, 16'd8000);
    end
    check("t2 ch0 out_ch", 64'(ch1o), 64'd0);
    check("t2 ch0 out_ave", 64'(ave1), 64'd250);
    check("t2 ch0 out_scaled", 64'(sc1), 64'd38);
    check("t2 ch0 dut2 scaled", 64'(sc2), 64'd500);
    repeat (2) @(negedge clk);
    check("t2 ch1 out_ch", 64'(ch1o), 64'd1);
    check("t2 ch1 out_ave", 64'(ave1), 64'd8000);
    check("t2 ch1 out_scaled", 64'(sc1), 64'd1220);
    check("t2 ch1 dut2 scaled", 64'(sc2), 64'd16000);
    @(negedge clk);

    // 3: stalled consumer -> second result dropped, overrun, clear
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sample(2'd0, 16'd1000);
    for (int i = 0; i < 4; i++) sample(2'd1, 16'd2000);
    repeat (2) @(negedge clk);
    check("t3 held valid", 64'(v1), 64'd1);
    check("t3 held ch", 64'(ch1o), 64'd0);
    check("t3 held ave", 64'(ave1), 64'd1000);
    check("t3 overrun", 64'(ovr1), 64'd1);
`ifdef ADC_PROC_DROP_CNT_EN
    check("t3 drop_cnt", 64'(dc1), 64'd1);
`endif
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("t3 overrun cleared", 64'(ovr1), 64'd0);
    check("t3 still held", 64'(ave1), 64'd1000);
`ifdef ADC_PROC_DROP_CNT_EN
    check("t3 drop_cnt cleared", 64'(dc1), 64'd0);
`endif
    out_ready = 1'b1;
    @(negedge clk);
    check("t3 drained", 64'(v1), 64'd0);

    // 4: saturation on dut2
    for (int i = 0; i < 4; i++) sample(2'd2, 16'h9000);
    repeat (2) @(negedge clk);
    check("t4 dut2 out_ave", 64'(ave2), 64'h9000);
    check("t4 dut2 out_scaled", 64'(sc2), 64'hFFFF);
    check("t4 dut1 out_scaled", 64'(sc1), 64'd5624);
    @(negedge clk);

    // 5: partial sum discarded by reset; ch3 ignored by the 3-channel dut2
    for (int i = 0; i < 2; i++) sample(2'd3, 16'd500);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) sample(2'd3, 16'd10);
    repeat (2) @(negedge clk);
    check("t5 out_ch", 64'(ch1o), 64'd3);
    check("t5 out_ave", 64'(ave1), 64'd10);
    check("t5 out_scaled", 64'(sc1), 64'd1);
    check("t5 dut2 ignored", 64'(v2), 64'd0);
    @(negedge clk);

    // 6: level high across reset release is not a sample
    adc_ch = 2'd0; adc_data = 16'd1000; adc_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    adc_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) sample(2'd0, 16'd8);
    repeat (2) @(negedge clk);
    check("t6 out_ave", 64'(ave1), 64'd8);
    check("t6 out_scaled", 64'(sc1), 64'd1);
    check("t6 dut2 out_scaled", 64'(sc2), 64'd16);
    @(negedge clk);

    // 7: mixed stream with a toggling consumer and occasional clears
    for (int i = 0; i < 32; i++) begin
      out_ready = (i % 3) != 0;
      ovr_clr = (i % 5) == 4;
      sample(2'(i % 4), 16'(i * 1234 + 7));
    end
    out_ready = 1'b1;
    ovr_clr = 1'b0;
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
